serial_addsub: RTL

Bit-serial adder/subtractor that complements the team's combinational full-adder/full-subtractor cells. It accepts two WIDTH-bit operands and a mode bit through a valid/ready handshake. It processes one bit per clock, LSB first, through a single full-adder/full-subtractor cell with a registered carry/borrow. It then presents the result, carry/borrow and signed overflow through an output valid/ready handshake. It is the area-minimal arithmetic option for datapaths where latency is not critical.

---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/serial_addsub_if.sv | 25 ++
 rtl/fa_fs_cell.sv | 20 ++
 rtl/serial_addsub.sv | 95 +++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Counter must hold 0..width so it never wraps on the final bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand-in / result-out handshake bundle for serial_addsub.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/fa_fs_cell.sv
// One-bit full adder / full subtractor; mode selects carry or borrow logic.
module fa_fs_cell
    import serial_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);
    always_comb begin
        s = x ^ y ^ cin;
        if (mode == MODE_SUB) begin
            cout = (~x & y) | (~x & cin) | (y & cin);
        end else begin
            cout = (x & y) | (x & cin) | (y & cin);
        end
    end
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: LSB first through one cell with a registered carry/borrow.
//  state | meaning
//  IDLE  | ready for operands
//  RUN   | one bit per cycle through the cell
//  DONE  | result presented until out_ready
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt_q;
    logic             mode_q, carry_q, a_msb_q, b_msb_q;
    logic             cell_s, cell_c;
    logic             accept, last_bit;
    logic             in_ready_c, out_valid_c;

    fa_fs_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry_q),
        .mode (mode_q),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ADD;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sr    <= bus.a;
                b_sr    <= bus.b;
                mode_q  <= bus.sub;
                a_msb_q <= bus.a[WIDTH-1];
                b_msb_q <= bus.b[WIDTH-1];
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                res_sr  <= {cell_s, res_sr[WIDTH-1:1]};
                carry_q <= cell_c;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    // Overflow uses operand MSBs captured at accept, since the shift registers are drained by then.
    assign bus.in_ready  = in_ready_c & ~rst;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = res_sr;
    assign bus.cout      = carry_q;
    assign bus.ovf       = out_valid_c & (res_sr[WIDTH-1] != a_msb_q) &
                           ((mode_q == MODE_SUB) ? (a_msb_q != b_msb_q) : (a_msb_q == b_msb_q));
endmodule
